// File: rtl/bcd_serial_add_ctrl_pkg.sv
// ============================================================================
// bcd_serial_add_ctrl_pkg
// Shared state encoding and BCD constants for the serial BCD adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] BCD_MAX  = 5'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;

endpackage

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_if.sv
// ============================================================================
// bcd_serial_add_ctrl_if
// Operand/result/handshake bundle between the operand source and the adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 3
);
  logic                  start;
  logic                  c_in;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic [4*DIGITS-1:0]   S;
  logic                  c_out;
  logic                  err;
  logic                  busy;
  logic                  done;

  modport master (
    output start, c_in, A, B,
    input  S, c_out, err, busy, done
  );

  modport slave (
    input  start, c_in, A, B,
    output S, c_out, err, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_digit_adder.sv
// ============================================================================
// bcd_digit_adder
// One-digit BCD add with +6 decimal correction and non-BCD digit flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adder
  import bcd_serial_add_ctrl_pkg::*;
(
  input  wire logic       c_in,
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  output logic      [3:0] s,
  output logic            c_out,
  output logic            bad
);

  logic [4:0] w_bin;
  logic [4:0] w_corr;
  logic       w_over;

  assign w_bin  = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
  assign w_over = (w_bin > BCD_MAX);
  assign w_corr = w_bin + BCD_CORR;

  // Correction wraps mod 16; only the low nibble is kept.
  assign s     = w_over ? w_corr[3:0] : w_bin[3:0];
  assign c_out = w_over;
  assign bad   = ({1'b0, a} > BCD_MAX) | ({1'b0, b} > BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// bcd_serial_add_ctrl
// Sequences a single BCD digit slice over DIGITS cycles, LSD first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  bcd_serial_add_ctrl_if.slave   bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_s;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_err;
  logic            r_cout;

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_sum;
  logic            w_carry;
  logic            w_bad;
  logic            w_last;
  logic            w_err_nxt;

  always_comb begin
    w_a_dig = 4'd0;
    w_b_dig = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_idx == IW'(d)) begin
        w_a_dig = r_a[4*d +: 4];
        w_b_dig = r_b[4*d +: 4];
      end
    end
  end

  bcd_digit_adder u_digit (
    .c_in  (r_carry),
    .a     (w_a_dig),
    .b     (w_b_dig),
    .s     (w_sum),
    .c_out (w_carry),
    .bad   (w_bad)
  );

  assign w_last    = (r_idx == IW'(DIGITS - 1));
  assign w_err_nxt = r_err | w_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.c_in;
            r_idx   <= '0;
            r_s     <= '0;
            r_err   <= 1'b0;
            r_cout  <= 1'b0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_err   <= w_err_nxt;
          r_carry <= w_carry;
          for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == IW'(d)) r_s[4*d +: 4] <= w_sum;
          end
          if (w_last) begin
            r_state <= DONE;
            // A bad digit anywhere invalidates the whole result.
            if (w_err_nxt) begin
              r_s    <= '0;
              r_cout <= 1'b0;
            end else begin
              r_cout <= w_carry;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.S     = r_s;
  assign bus.c_out = r_cout;
  assign bus.err   = r_err;
  assign bus.busy  = (r_state == RUN);
  assign bus.done  = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// tb_bcd_serial_add_ctrl
// Self-checking bench: decimal-arithmetic reference model, random operands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

  localparam int DG = 3;
  localparam int W  = 4 * DG;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  bcd_serial_add_ctrl_if #(.DIGITS(DG)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd_val(input logic [W-1:0] x);
    int v = 0;
    for (int i = DG - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] x);
    logic b = 1'b0;
    for (int i = 0; i < DG; i++) if (x[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [W-1:0] rand_operand(input logic allow_bad);
    logic [W-1:0] r;
    for (int i = 0; i < DG; i++) begin
      if (allow_bad && ($urandom_range(0, 7) == 0)) r[4*i +: 4] = 4'($urandom_range(10, 15));
      else r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Full operation; inputs are scrambled right after capture.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input string tag);
    logic          bad;
    int            total;
    int            modv;
    logic [W-1:0]  exp_s;
    logic          exp_c;
    modv  = 1;
    for (int i = 0; i < DG; i++) modv = modv * 10;
    bad   = has_bad(a) | has_bad(b);
    total = bcd_val(a) + bcd_val(b) + int'(ci);
    exp_s = bad ? '0 : to_bcd(total % modv);
    exp_c = bad ? 1'b0 : (total >= modv);

    @(negedge clk);
    bus.A = a; bus.B = b; bus.c_in = ci; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.c_in = 1'($urandom);
    for (int i = 0; i < DG; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "/busy"}, 32'(bus.busy), 32'd1);
      check({tag, "/done_lo"}, 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check({tag, "/done"}, 32'(bus.done), 32'd1);
    check({tag, "/busy_lo"}, 32'(bus.busy), 32'd0);
    check({tag, "/S"}, 32'(bus.S), 32'(exp_s));
    check({tag, "/c_out"}, 32'(bus.c_out), 32'(exp_c));
    check({tag, "/err"}, 32'(bus.err), 32'(bad));
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/S_hold"}, 32'(bus.S), 32'(exp_s));
    check({tag, "/err_hold"}, 32'(bus.err), 32'(bad));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.c_in = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    check("rst/S", 32'(bus.S), 32'd0);
    check("rst/c_out", 32'(bus.c_out), 32'd0);
    check("rst/err", 32'(bus.err), 32'd0);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    run_add(12'h123, 12'h456, 1'b0, "d123_456");
    run_add(12'h999, 12'h001, 1'b0, "d999_001");
    run_add(12'h000, 12'h000, 1'b1, "d000_cin");
    run_add(12'h999, 12'h999, 1'b1, "d999_999");
    run_add(12'h1A3, 12'h100, 1'b0, "dbad");
    run_add(12'h250, 12'h250, 1'b0, "d250_250");

    // Start held high: one result every DG+1 cycles, no extra done.
    @(negedge clk);
    bus.A = 12'h005; bus.B = 12'h005; bus.c_in = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 3 * (DG + 1); c++) begin
      @(negedge clk);
      check("hold/done", 32'(bus.done), 32'((c % (DG + 1)) == 0));
      check("hold/busy", 32'(bus.busy), 32'((c % (DG + 1)) != 0));
      if ((c % (DG + 1)) == 0) begin
        check("hold/S", 32'(bus.S), 32'h010);
        check("hold/c_out", 32'(bus.c_out), 32'd0);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("hold/idle", 32'(bus.busy) | 32'(bus.done), 32'd0);

    // Reset during the second RUN cycle discards the partial result.
    bus.A = 12'h555; bus.B = 12'h555; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid/busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst/S", 32'(bus.S), 32'd0);
    check("mid_rst/flags", {28'd0, bus.c_out, bus.err, bus.busy, bus.done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst/idle", 32'(bus.busy) | 32'(bus.done), 32'd0);
    run_add(12'h555, 12'h555, 1'b0, "d555_555");

    for (int n = 0; n < 25; n++) begin
      run_add(rand_operand(1'b1), rand_operand(1'b1), 1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
